interrupt_controller: RTL and testbench

- Prioritised 8-input interrupt controller between the I/O devices and the cpu core.
- Edge-detects requests on IO[7:0] and latches them as pending.
- Applies the enable mask IMR_in, raises INT to the cpu and presents a synthesised interrupt instruction on INT_INSTR.
- Holds the request until the cpu answers on ACK; otherwise drives a NOP instruction.

---
 rtl/interrupt_controller.sv | 118 +++++++++++
 tb/tb_interrupt_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// interrupt_controller
//
// Prioritised 8-input interrupt controller sitting between the I/O devices and
// the cpu core. Rising edges on IO are synchronised, edge-detected and latched
// as pending in IRR. The lowest-index pending source that is enabled in IMR_in
// is presented to the cpu on INT together with a synthesised interrupt
// instruction on INT_INSTR, and held until the cpu acknowledges it. A one-cycle
// DONE state after each acknowledge guarantees at least two low cycles of INT
// between consecutive requests.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst_n      synchronous reset, active HIGH despite the name
//   IO[7:0]    asynchronous request lines, a request is a rising edge
//   IMR_in     enable mask, bit i = 1 enables source i
//   ACK        cpu acknowledge, only sampled while a request is presented
//   INT        registered interrupt request to the cpu
//   INT_INSTR  registered instruction handed to the cpu (NOP when idle)

module interrupt_controller #(
    parameter logic [4:0]  INT_OPCODE = 5'b01110,
    parameter logic [31:0] NOP_INSTR  = 32'h7800_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  IO,
    input  logic [7:0]  IMR_in,
    input  logic        ACK,
    output logic        INT,
    output logic [31:0] INT_INSTR
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic [2:0] id;
    logic [7:0] sync1;
    logic [7:0] sync2;
    logic [7:0] prev;
    logic [7:0] irr;

    logic [7:0] rise;
    logic [7:0] elig;
    logic [7:0] ack_clr;
    logic [7:0] irr_next;
    logic [2:0] pick_id;

    assign rise = sync2 & ~prev;
    assign elig = irr & IMR_in;

    // Descending scan so the lowest set index is the one left standing.
    always_comb begin
        pick_id = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (elig[i]) begin
                pick_id = i[2:0];
            end
        end
    end

    // A fresh rise on the acknowledged bit is OR-ed in after the clear, so
    // the new request survives.
    always_comb begin
        ack_clr = 8'b0;
        if (state == REQ && ACK) begin
            ack_clr[id] = 1'b1;
        end
        irr_next = (irr & ~ack_clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            sync1     <= 8'b0;
            sync2     <= 8'b0;
            prev      <= 8'b0;
            irr       <= 8'b0;
            state     <= IDLE;
            id        <= 3'd0;
            INT       <= 1'b0;
            INT_INSTR <= NOP_INSTR;
        end else begin
            sync1 <= IO;
            sync2 <= sync1;
            prev  <= sync2;
            irr   <= irr_next;
            case (state)
                IDLE: begin
                    if (|elig) begin
                        id        <= pick_id;
                        state     <= REQ;
                        INT       <= 1'b1;
                        INT_INSTR <= {INT_OPCODE, 24'b0, pick_id};
                    end
                end
                // Presented request is frozen until ACK; mask and new
                // requests are deliberately ignored here.
                REQ: begin
                    if (ACK) begin
                        state     <= DONE;
                        INT       <= 1'b0;
                        INT_INSTR <= NOP_INSTR;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    INT       <= 1'b0;
                    INT_INSTR <= NOP_INSTR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios with literal
// expectations, then a randomized phase, all tracked by a behavioural model.

module tb_interrupt_controller;

    logic        clk;
    logic        rst_n;
    logic [7:0]  IO;
    logic [7:0]  IMR_in;
    logic        ACK;
    logic        INT;
    logic [31:0] INT_INSTR;

    interrupt_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .IO        (IO),
        .IMR_in    (IMR_in),
        .ACK       (ACK),
        .INT       (INT),
        .INT_INSTR (INT_INSTR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Behavioural model: sampled-IO history, pending flags, the id currently
    // presented (-1 if none) and a cooldown count of forced-idle edges.
    logic [7:0] h0, h1, h2;
    logic [7:0] pend;
    int         pres = -1;
    int         cool = 0;
    logic [7:0] m_rise, m_clr, m_elig;
    int         m_pick;

    always @(posedge clk) begin
        if (rst_n) begin
            h0 = 8'h00; h1 = 8'h00; h2 = 8'h00;
            pend = 8'h00; pres = -1; cool = 0;
        end else begin
            m_rise = h1 & ~h2;
            m_clr  = 8'h00;
            if (pres >= 0) begin
                if (ACK) begin
                    m_clr[pres] = 1'b1;
                    pres = -1;
                    cool = 1;
                end
            end else if (cool > 0) begin
                cool = cool - 1;
            end else begin
                m_elig = pend & IMR_in;
                m_pick = -1;
                for (int i = 0; i < 8; i++) begin
                    if (m_elig[i] && m_pick < 0) m_pick = i;
                end
                pres = m_pick;
            end
            pend = (pend & ~m_clr) | m_rise;
            h2 = h1; h1 = h0; h0 = IO;
        end
    end

    function automatic logic [31:0] exp_instr();
        if (pres >= 0) return 32'h7000_0000 + pres;
        return 32'h7800_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_int", {31'b0, INT}, {31'b0, (pres >= 0)});
            check("model_instr", INT_INSTR, exp_instr());
            check("model_irr", {24'b0, dut.irr}, {24'b0, pend});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_int(input int budget, output int n);
        n = 0;
        while (n < budget && INT !== 1'b1) begin
            tick();
            n++;
        end
        check("int_rise_timeout", {31'b0, INT}, 32'd1);
    endtask

    task automatic pulse_io(input logic [7:0] v);
        IO = v;
        tick();
        IO = 8'h00;
    endtask

    task automatic ack_pulse();
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
    endtask

    int n;
    bit saw;

    initial begin
        rst_n = 1'b1; IO = 8'hFF; IMR_in = 8'hFF; ACK = 1'b0;

        // 1: reset
        tick();
        chk_en = 1;
        repeat (9) tick();
        check("rst_int", {31'b0, INT}, 32'd0);
        check("rst_instr", INT_INSTR, 32'h7800_0000);
        IO = 8'h00;
        rst_n = 1'b0;
        saw = 0;
        repeat (10) begin tick(); saw |= INT; end
        check("rst_no_int", {31'b0, saw}, 32'd0);

        // 2: single request, four edges from sampling to INT
        pulse_io(8'h08);
        wait_int(20, n);
        check("single_latency", n, 32'd3);
        check("single_instr", INT_INSTR, 32'h7000_0003);
        ack_pulse();
        check("single_ack_int", {31'b0, INT}, 32'd0);
        check("single_ack_instr", INT_INSTR, 32'h7800_0000);
        check("single_ack_irr", {24'b0, dut.irr}, 32'd0);
        repeat (3) tick();

        // 3: priority, lowest index first, two low cycles in between
        pulse_io(8'h22);
        wait_int(20, n);
        check("prio_first", INT_INSTR, 32'h7000_0001);
        ack_pulse();
        check("prio_low1", {31'b0, INT}, 32'd0);
        tick();
        check("prio_low2", {31'b0, INT}, 32'd0);
        tick();
        check("prio_second_int", {31'b0, INT}, 32'd1);
        check("prio_second", INT_INSTR, 32'h7000_0005);
        ack_pulse();
        tick();
        check("prio_idle_irr", {24'b0, dut.irr}, 32'd0);
        check("prio_idle_int", {31'b0, INT}, 32'd0);

        // 4: masking keeps the bit pending until unmasked
        IMR_in = 8'hFE;
        pulse_io(8'h01);
        saw = 0;
        repeat (20) begin tick(); saw |= INT; end
        check("mask_hold", {31'b0, saw}, 32'd0);
        IMR_in = 8'hFF;
        wait_int(2, n);
        check("mask_release_instr", INT_INSTR, 32'h7000_0000);
        ack_pulse();
        repeat (3) tick();

        // 5: no withdrawal, then held ACK services ids 2 and 0 in order
        pulse_io(8'h04);
        wait_int(20, n);
        check("hold_instr", INT_INSTR, 32'h7000_0002);
        IMR_in = 8'h00;
        pulse_io(8'h01);
        saw = 0;
        repeat (6) begin tick(); saw |= (INT_INSTR !== 32'h7000_0002) || (INT !== 1'b1); end
        check("hold_stable", {31'b0, saw}, 32'd0);
        check("hold_irr", {24'b0, dut.irr}, 32'h05);
        IMR_in = 8'hFF;
        ACK = 1'b1;
        tick();
        check("hack_irr1", {24'b0, dut.irr}, 32'h01);
        check("hack_int1", {31'b0, INT}, 32'd0);
        tick();
        check("hack_int2", {31'b0, INT}, 32'd0);
        tick();
        check("hack_int3", {31'b0, INT}, 32'd1);
        check("hack_instr3", INT_INSTR, 32'h7000_0000);
        tick();
        check("hack_irr4", {24'b0, dut.irr}, 32'h00);
        check("hack_int4", {31'b0, INT}, 32'd0);
        tick();
        ACK = 1'b0;
        repeat (3) tick();

        // 6: reset mid-request
        pulse_io(8'h10);
        wait_int(20, n);
        IO = 8'h40;
        rst_n = 1'b1;
        tick();
        IO = 8'h00;
        rst_n = 1'b0;
        check("mrst_int", {31'b0, INT}, 32'd0);
        check("mrst_instr", INT_INSTR, 32'h7800_0000);
        check("mrst_irr", {24'b0, dut.irr}, 32'd0);
        saw = 0;
        repeat (10) begin tick(); saw |= INT; end
        check("mrst_quiet", {31'b0, saw}, 32'd0);

        // Randomized phase, checked every cycle by the model
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 5) == 0) IO[b] = ~IO[b];
            end
            ACK = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) IMR_in = 8'($urandom);
            rst_n = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst_n = 1'b0; ACK = 1'b0; IO = 8'h00;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
